io_hex_display: RTL and testbench
=================================

// Module: io_hex_display
// PURPOSE
//  Consumes the CPU's memory-mapped output ports and shows each as two decimal digits on the board's six active-low 7-segment displays.
//  Sits directly downstream of the MEM-stage I/O output register bank; reads its out_port0..2 values and never writes back to the CPU.
//  A sequential double-dabble converter services ports 0..2 round-robin, then idles for a programmable refresh gap.
// PARAMETERS
//  REFRESH_DIV  1000  idle cycles between full 3-port refresh frames; legal range >=1
//  BIN_W        7     width of the value converted per port; 7 bits covers 0..99
// PORTS
//  clock       in   1   single system clock; every register updates on its rising edge
//  resetn      in   1   asynchronous, active-low reset
//  out_port0   in   32  value for hex1:hex0 (tens:ones)
//  out_port1   in   32  value for hex3:hex2
//  out_port2   in   32  value for hex5:hex4
//  hex0..hex5  out  7   segments {g,f,e,d,c,b,a}, active-low, each individually registered
//  busy        out  1   high while in LOAD, SHIFT or COMMIT
//  frame_done  out  1   one-cycle pulse in the cycle after port2's COMMIT edge
// BEHAVIOUR
//  Reset (async, resetn=0): all hex = 7'h7F (blank); busy=0; frame_done=0; state=WAIT; wait counter=0; port select=0.
//  States and transitions:
//    WAIT: counter counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 -> LOAD with sel=0, counter cleared.
//    LOAD (1 cycle): capture out_port[sel] into a 32-bit shadow register.
//      ovf = (shadow > 99), compared over all 32 bits.
//      Clear the BCD accumulator; load the shift register with shadow[BIN_W-1:0].
//    SHIFT (BIN_W cycles): for each BCD nibble >=5, add 3; then shift {bcd, bin} left by 1.
//      The shift counter ends at BIN_W-1 -> COMMIT.
//    COMMIT (1 cycle): write the encoded tens/ones into the hex pair for sel.
//      If ovf, both digits of the pair = dash 7'h3F.
//      If sel<2: sel++ -> LOAD. If sel==2: sel=0 -> WAIT, and frame_done asserts on the next cycle.
//  Timing: port0's pair updates on rising edge REFRESH_DIV+BIN_W+2 after reset release.
//    Each later port follows BIN_W+2 edges after the previous one.
//    Frame period = REFRESH_DIV + 3*(BIN_W+2) cycles.
//  Sampling: inputs are sampled only in LOAD. Input changes during SHIFT/COMMIT do not affect the current conversion; they appear next frame.
//  Untouched pairs keep their last value. Only the sel pair changes at COMMIT.
//  Digit encodings: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); blank=7F; dash=3F.
//  Boundary values:
//    Value 99 -> "99".
//    Value 100 -> "--".
//    Value 32'hFFFFFFFF -> "--". The upper bits are never ignored.
//  Reset asserted mid-SHIFT or mid-COMMIT: immediately blanks all displays. No partial commit survives.
//  frame_done and busy are never high together.
// CONFIGURATION
//  HEX_LZB_EN defined: leading-zero blanking. A tens digit of 0 shows blank 7'h7F, so value 7 -> hex1=7F, hex0=78.
//    Value 0 shows blank tens and '0' ones. Dash pairs are unaffected.
//  HEX_LZB_EN undefined: the tens digit always shows, so value 7 -> hex1=40, hex0=78.
// TESTING
//  T1 reset: hold resetn=0, toggle ports -> all hex=7F, busy=0, frame_done=0.
//  T2 REFRESH_DIV=4: ports=12,34,56, release reset.
//    -> At edge 13: hex1=79, hex0=24. At edge 22: hex3=30, hex2=19. At edge 31: hex5=12, hex4=02.
//    -> frame_done is high in the cycle after edge 31 (one cycle).
//  T3 ports=99,100,32'h8000_0005 -> hex1/0=10/10; hex3/2=3F/3F; hex5/4=3F/3F.
//  T4 change out_port1 from 34 to 78 during port1's SHIFT.
//    -> this frame shows 34; the next frame shows hex3=78, hex2=00.
//  T5 assert resetn=0 mid-SHIFT of port2 after one full frame -> all hex=7F at once.
//    -> After release, the timing of T2 repeats exactly.
//  T6 port0=7: with HEX_LZB_EN -> hex1=7F, hex0=78; without it -> hex1=40, hex0=78.

Source files
------------

// File: rtl/io_hex_display_if.sv
// Bundle between the CPU output-port bank and the 7-segment display block.
// The master owns the out_port values; the slave owns the hex/status outputs.
interface io_hex_display_if;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] out_port2;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic [6:0]  hex4;
    logic [6:0]  hex5;
    logic        busy;
    logic        frame_done;

    modport master (
        output out_port0, out_port1, out_port2,
        input  hex0, hex1, hex2, hex3, hex4, hex5, busy, frame_done
    );

    modport slave (
        input  out_port0, out_port1, out_port2,
        output hex0, hex1, hex2, hex3, hex4, hex5, busy, frame_done
    );
endinterface

// File: rtl/io_hex_display.sv
// Shows out_port0..2 as two decimal digits each (7-seg, active-low); values >99 show "--". HEX_LZB_EN blanks a leading zero.
// Latency: a port's pair updates BIN_W+2 cycles after its LOAD; a frame is REFRESH_DIV + 3*(BIN_W+2) cycles.
// No backpressure: inputs are sampled only in LOAD, and the display never stalls the CPU.
module io_hex_display #(
    parameter int REFRESH_DIV = 1000,
    parameter int BIN_W       = 7
) (
    input  logic             clock,
    input  logic             resetn,
    io_hex_display_if.slave  io
);

    localparam int WC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SC_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [SC_W-1:0]   scnt_q, scnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [7:0]        bcd_q, bcd_d;
    logic [6:0]        hex_q [0:5];
    logic [6:0]        hex_d [0:5];
    logic              frame_done_q, frame_done_d;

    logic [31:0]       port_sel;
    logic              ovf;
    logic [6:0]        seg_tens, seg_ones;
    logic [7+BIN_W:0]  shv;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction applied to each BCD nibble before the shift.
    function automatic logic [7:0] dd_adj(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        return r;
    endfunction

    always_comb begin
        case (sel_q)
            2'd0:    port_sel = io.out_port0;
            2'd1:    port_sel = io.out_port1;
            default: port_sel = io.out_port2;
        endcase
    end

    // Overflow judged on the full 32-bit shadow so upper bits cannot alias into 0..99.
    assign ovf = (shadow_q > 32'd99);
    assign shv = {dd_adj(bcd_q), bin_q} << 1;

    always_comb begin
        seg_ones = seg7(bcd_q[3:0]);
`ifdef HEX_LZB_EN
        seg_tens = (bcd_q[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
`else
        seg_tens = seg7(bcd_q[7:4]);
`endif
        if (ovf) begin
            seg_ones = SEG_DASH;
            seg_tens = SEG_DASH;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        scnt_d       = scnt_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        hex_d        = hex_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (wcnt_q == WC_W'(REFRESH_DIV - 1)) begin
                    wcnt_d  = '0;
                    sel_d   = 2'd0;
                    state_d = ST_LOAD;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                shadow_d = port_sel;
                bin_d    = port_sel[BIN_W-1:0];
                bcd_d    = '0;
                scnt_d   = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d = shv[7+BIN_W:BIN_W];
                bin_d = shv[BIN_W-1:0];
                if (scnt_q == SC_W'(BIN_W - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                case (sel_q)
                    2'd0: begin
                        hex_d[1] = seg_tens;
                        hex_d[0] = seg_ones;
                    end
                    2'd1: begin
                        hex_d[3] = seg_tens;
                        hex_d[2] = seg_ones;
                    end
                    default: begin
                        hex_d[5] = seg_tens;
                        hex_d[4] = seg_ones;
                    end
                endcase
                if (sel_q == 2'd2) begin
                    sel_d        = 2'd0;
                    wcnt_d       = '0;
                    frame_done_d = 1'b1;
                    state_d      = ST_WAIT;
                end else begin
                    sel_d   = sel_q + 2'd1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_WAIT;
            wcnt_q       <= '0;
            scnt_q       <= '0;
            sel_q        <= 2'd0;
            shadow_q     <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            scnt_q       <= scnt_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
        end
    end

    assign io.hex0       = hex_q[0];
    assign io.hex1       = hex_q[1];
    assign io.hex2       = hex_q[2];
    assign io.hex3       = hex_q[3];
    assign io.hex4       = hex_q[4];
    assign io.hex5       = hex_q[5];
    assign io.busy       = (state_q != ST_WAIT);
    assign io.frame_done = frame_done_q;

endmodule

// File: tb/tb_io_hex_display.sv
// Directed bench for io_hex_display with REFRESH_DIV=4, BIN_W=7 (frame = 31 cycles).
module tb_io_hex_display;

    logic clock;
    logic resetn;
    int   n_chk;
    int   n_fail;
    int   edge_n;

    io_hex_display_if dif ();

    io_hex_display #(
        .REFRESH_DIV (4),
        .BIN_W       (7)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .io     (dif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to rising edge n (counted from reset release) and sample 1 unit later.
    task automatic to_edge(input int n);
        while (edge_n < n) begin
            @(posedge clock);
            edge_n++;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        resetn = 1'b1;
        edge_n = 0;
    endtask

    task automatic set_ports(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
        dif.out_port0 = p0;
        dif.out_port1 = p1;
        dif.out_port2 = p2;
    endtask

    task automatic check_blank(input string tag);
        chk({tag, "_hex0"}, {25'd0, dif.hex0}, 32'h7F);
        chk({tag, "_hex1"}, {25'd0, dif.hex1}, 32'h7F);
        chk({tag, "_hex2"}, {25'd0, dif.hex2}, 32'h7F);
        chk({tag, "_hex3"}, {25'd0, dif.hex3}, 32'h7F);
        chk({tag, "_hex4"}, {25'd0, dif.hex4}, 32'h7F);
        chk({tag, "_hex5"}, {25'd0, dif.hex5}, 32'h7F);
        chk({tag, "_busy"}, {31'd0, dif.busy}, 32'd0);
        chk({tag, "_fdone"}, {31'd0, dif.frame_done}, 32'd0);
    endtask

    // First frame after reset release with ports 12,34,56.
    task automatic check_first_frame(input string tag);
        to_edge(12);
        chk({tag, "_e12_hex1"}, {25'd0, dif.hex1}, 32'h7F);
        chk({tag, "_e12_busy"}, {31'd0, dif.busy}, 32'd1);
        to_edge(13);
        chk({tag, "_e13_hex1"}, {25'd0, dif.hex1}, 32'h79);
        chk({tag, "_e13_hex0"}, {25'd0, dif.hex0}, 32'h24);
        chk({tag, "_e13_hex3"}, {25'd0, dif.hex3}, 32'h7F);
        to_edge(21);
        chk({tag, "_e21_hex3"}, {25'd0, dif.hex3}, 32'h7F);
        to_edge(22);
        chk({tag, "_e22_hex3"}, {25'd0, dif.hex3}, 32'h30);
        chk({tag, "_e22_hex2"}, {25'd0, dif.hex2}, 32'h19);
        to_edge(30);
        chk({tag, "_e30_hex5"}, {25'd0, dif.hex5}, 32'h7F);
        chk({tag, "_e30_fdone"}, {31'd0, dif.frame_done}, 32'd0);
        to_edge(31);
        chk({tag, "_e31_hex5"}, {25'd0, dif.hex5}, 32'h12);
        chk({tag, "_e31_hex4"}, {25'd0, dif.hex4}, 32'h02);
        chk({tag, "_e31_fdone"}, {31'd0, dif.frame_done}, 32'd1);
        chk({tag, "_e31_busy"}, {31'd0, dif.busy}, 32'd0);
        to_edge(32);
        chk({tag, "_e32_fdone"}, {31'd0, dif.frame_done}, 32'd0);
        chk({tag, "_e32_hex1"}, {25'd0, dif.hex1}, 32'h79);
    endtask

    initial begin
        logic [6:0] exp_tens7;
        n_chk  = 0;
        n_fail = 0;
        edge_n = 0;
        resetn = 1'b0;
        set_ports(32'd0, 32'd0, 32'd0);

        // T1: reset held while ports toggle
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            set_ports(32'd11 * i, 32'hFFFF_FFFF - i, 32'd50 + i);
        end
        #1;
        check_blank("t1");

        // T2: first frame timing
        set_ports(32'd12, 32'd34, 32'd56);
        release_reset();
        check_first_frame("t2");

        // T3: boundary values in the second frame (commits at 44, 53, 62)
        set_ports(32'd99, 32'd100, 32'h8000_0005);
        to_edge(44);
        chk("t3_hex1", {25'd0, dif.hex1}, 32'h10);
        chk("t3_hex0", {25'd0, dif.hex0}, 32'h10);
        chk("t3_hex3_old", {25'd0, dif.hex3}, 32'h30);
        to_edge(53);
        chk("t3_hex3", {25'd0, dif.hex3}, 32'h3F);
        chk("t3_hex2", {25'd0, dif.hex2}, 32'h3F);
        to_edge(62);
        chk("t3_hex5", {25'd0, dif.hex5}, 32'h3F);
        chk("t3_hex4", {25'd0, dif.hex4}, 32'h3F);
        chk("t3_fdone", {31'd0, dif.frame_done}, 32'd1);

        // T6 + T4 setup: third frame (commits at 75, 84, 93)
        set_ports(32'd7, 32'd34, 32'd56);
`ifdef HEX_LZB_EN
        exp_tens7 = 7'h7F;
`else
        exp_tens7 = 7'h40;
`endif
        to_edge(75);
        chk("t6_hex1", {25'd0, dif.hex1}, {25'd0, exp_tens7});
        chk("t6_hex0", {25'd0, dif.hex0}, 32'h78);

        // T4: port1 changes mid-SHIFT (shift edges 77..83)
        to_edge(78);
        chk("t4_busy", {31'd0, dif.busy}, 32'd1);
        dif.out_port1 = 32'd78;
        to_edge(84);
        chk("t4_hex3_old", {25'd0, dif.hex3}, 32'h30);
        chk("t4_hex2_old", {25'd0, dif.hex2}, 32'h19);
        to_edge(93);
        chk("t4_hex5", {25'd0, dif.hex5}, 32'h12);
        chk("t4_hex4", {25'd0, dif.hex4}, 32'h02);
        to_edge(115);
        chk("t4_hex3_new", {25'd0, dif.hex3}, 32'h78);
        chk("t4_hex2_new", {25'd0, dif.hex2}, 32'h00);

        // T5: reset mid-SHIFT of port2 (shift edges 117..123)
        to_edge(120);
        chk("t5_busy_pre", {31'd0, dif.busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check_blank("t5");
        repeat (3) @(posedge clock);
        set_ports(32'd12, 32'd34, 32'd56);
        release_reset();
        check_first_frame("t5r");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
